sockit_spi_axi_regs: RTL and testbench

//  AXI4-Lite register file for the SPI master; successor of the basic cfg/ctl/irq/off block.

---
 rtl/sockit_spi_axi_regs.sv | 275 +++++++++++++++++++++++++++
 tb/tb_sockit_spi_axi_regs.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sockit_spi_axi_regs.sv
`default_nettype none
// ============================================================================
//  Module   : sockit_spi_axi_regs
//  Purpose  : AXI4-Lite register file for the SPI master. Holds the
//             configuration, XIP offset and interrupt registers and feeds
//             command words through a small FIFO to the SPI command stream.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    ACLK / ARESETn             clock, asynchronous active-low reset
//    AW* / W* / B*              AXI4-Lite write address, data, response
//    AR* / R*                   AXI4-Lite read address, data
//    cfg      [31:0]            configuration register
//    off      [XAW-1:0]         XIP address offset
//    scw_vld/scw_dat/scw_rdy    command word stream (FIFO head)
//    irq                        |(irq_sts & irq_en)
//  Map (ADDR[4:2]): 0 cfg, 1 sts, 2 irq_sts (W1C), 3 irq_en, 4 off,
//                   5 cmd (write-only), 6..7 reserved (SLVERR)
// ============================================================================
module sockit_spi_axi_regs #(
  parameter logic [31:0]    CFG_RST = 32'h0000_0000,
  parameter logic [31:0]    CFG_MSK = 32'hffff_ffff,
  parameter int unsigned    XAW     = 24,
  parameter logic [XAW-1:0] OFF_RST = '0,
  parameter int unsigned    CDEPTH  = 4
) (
  input  logic           ACLK,
  input  logic           ARESETn,
  input  logic           AWVALID,
  output logic           AWREADY,
  input  logic [4:0]     AWADDR,
  input  logic           WVALID,
  output logic           WREADY,
  input  logic [31:0]    WDATA,
  input  logic [3:0]     WSTRB,
  output logic           BVALID,
  input  logic           BREADY,
  output logic [1:0]     BRESP,
  input  logic           ARVALID,
  output logic           ARREADY,
  input  logic [4:0]     ARADDR,
  output logic           RVALID,
  input  logic           RREADY,
  output logic [31:0]    RDATA,
  output logic [1:0]     RRESP,
  output logic [31:0]    cfg,
  output logic [XAW-1:0] off,
  output logic           scw_vld,
  output logic [31:0]    scw_dat,
  input  logic           scw_rdy,
  output logic           irq
);

  localparam int unsigned PW = $clog2(CDEPTH);
  localparam int unsigned LW = PW + 1;

  localparam logic [2:0] ADDR_CFG     = 3'd0;
  localparam logic [2:0] ADDR_STS     = 3'd1;
  localparam logic [2:0] ADDR_IRQ_STS = 3'd2;
  localparam logic [2:0] ADDR_IRQ_EN  = 3'd3;
  localparam logic [2:0] ADDR_OFF     = 3'd4;
  localparam logic [2:0] ADDR_CMD     = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte-lane merge used by every WSTRB-qualified register.
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // State
  logic           rdy_en_q;
  logic           aw_held_q, aw_held_d;
  logic [2:0]     aw_idx_q,  aw_idx_d;
  logic           w_held_q,  w_held_d;
  logic [31:0]    w_data_q,  w_data_d;
  logic [3:0]     w_strb_q,  w_strb_d;
  logic           bvalid_q,  bvalid_d;
  logic [1:0]     bresp_q,   bresp_d;
  logic           rvalid_q,  rvalid_d;
  logic [31:0]    rdata_q,   rdata_d;
  logic [1:0]     rresp_q,   rresp_d;
  logic [31:0]    cfg_q,     cfg_d;
  logic [31:0]    irq_en_q,  irq_en_d;
  logic [XAW-1:0] off_q,     off_d;
  logic [1:0]     irq_sts_q, irq_sts_d;
  logic [PW-1:0]  wptr_q,    wptr_d;
  logic [PW-1:0]  rptr_q,    rptr_d;
  logic [LW-1:0]  level_q,   level_d;
  logic [31:0]    fifo_mem [CDEPTH];

  // Combinational helpers
  logic        aw_hs, w_hs, ar_hs;
  logic        fifo_full, is_cmd, is_rsv, commit, push, pop;
  logic [31:0] off_ext, off_merged, sts_val;
  logic [1:0]  sts_clr, sts_set;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

  // READY outputs stay low until the first clock after reset release.
  assign AWREADY = rdy_en_q & ~aw_held_q;
  assign WREADY  = rdy_en_q & ~w_held_q;
  assign ARREADY = rdy_en_q & (~rvalid_q | RREADY);

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID  & WREADY;
  assign ar_hs = ARVALID & ARREADY;

  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign cfg     = cfg_q;
  assign off     = off_q;
  assign scw_vld = (level_q != '0);
  assign scw_dat = fifo_mem[rptr_q];
  assign irq     = |(irq_sts_q & irq_en_q[1:0]);

  // Full is judged on the current level, so a pop in the same cycle does
  // not make room for a stalled command push.
  assign fifo_full = (level_q == LW'(CDEPTH));
  assign is_cmd    = (aw_idx_q == ADDR_CMD);
  assign is_rsv    = (aw_idx_q[2:1] == 2'b11);
  assign commit    = aw_held_q & w_held_q & (~bvalid_q | BREADY) & ~(is_cmd & fifo_full);
  assign push      = commit & is_cmd;
  assign pop       = scw_vld & scw_rdy;

  assign off_ext    = 32'(off_q);
  assign off_merged = f_merge(off_ext, w_data_q, w_strb_q);
  assign sts_val    = {scw_vld, 23'b0, 8'(level_q)};

  // W1C only through byte lane 0; hardware set events override the clear.
  assign sts_clr = (commit && aw_idx_q == ADDR_IRQ_STS && w_strb_q[0]) ? w_data_q[1:0] : 2'b00;
  assign sts_set = {commit & is_rsv, pop & ~push & (level_q == LW'(1))};

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    cfg_d     = cfg_q;
    irq_en_d  = irq_en_q;
    off_d     = off_q;
    irq_sts_d = (irq_sts_q & ~sts_clr) | sts_set;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    level_d   = level_q;

    // Address / data holding registers; a commit frees both.
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = AWADDR[4:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end

    // Write response
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = is_rsv ? RESP_SLVERR : RESP_OKAY;
    end else if (BREADY) begin
      bvalid_d = 1'b0;
    end

    // Register updates
    if (commit) begin
      case (aw_idx_q)
        ADDR_CFG:    cfg_d    = (f_merge(cfg_q, w_data_q, w_strb_q) & CFG_MSK) | (CFG_RST & ~CFG_MSK);
        ADDR_IRQ_EN: irq_en_d = f_merge(irq_en_q, w_data_q, w_strb_q);
        ADDR_OFF:    off_d    = off_merged[XAW-1:0];
        default:     ;
      endcase
    end

    // Command FIFO pointers and level
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Read channel: data captured at the AR handshake, held while stalled.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      case (ARADDR[4:2])
        ADDR_CFG:     rdata_d = cfg_q;
        ADDR_STS:     rdata_d = sts_val;
        ADDR_IRQ_STS: rdata_d = {30'b0, irq_sts_q};
        ADDR_IRQ_EN:  rdata_d = irq_en_q;
        ADDR_OFF:     rdata_d = off_ext;
        ADDR_CMD:     rdata_d = 32'h0;
        default: begin
          rdata_d = 32'h0;
          rresp_d = RESP_SLVERR;
        end
      endcase
    end else if (RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rdy_en_q  <= 1'b0;
      aw_held_q <= 1'b0;
      aw_idx_q  <= 3'd0;
      w_held_q  <= 1'b0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= RESP_OKAY;
      cfg_q     <= CFG_RST;
      irq_en_q  <= 32'h0;
      off_q     <= OFF_RST;
      irq_sts_q <= 2'b00;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
    end else begin
      rdy_en_q  <= 1'b1;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      cfg_q     <= cfg_d;
      irq_en_q  <= irq_en_d;
      off_q     <= off_d;
      irq_sts_q <= irq_sts_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
    end
  end

  // FIFO storage needs no reset: contents are invalidated by the pointers.
  always_ff @(posedge ACLK) begin
    if (push) fifo_mem[wptr_q] <= w_data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sockit_spi_axi_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sockit_spi_axi_regs
//  Purpose  : Self-checking bench for sockit_spi_axi_regs. Expected write
//             responses, read data and command words are queued when the
//             stimulus is driven and compared when the DUT delivers them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sockit_spi_axi_regs;

  localparam logic [31:0] P_CFG_RST = 32'h0000_0000;
  localparam logic [31:0] P_CFG_MSK = 32'h0000_ffff;
  localparam logic [23:0] P_OFF_RST = 24'h00_abcd;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [4:0]  AWADDR, ARADDR;
  logic [31:0] WDATA, RDATA, cfg, scw_dat;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic [23:0] off;
  logic        scw_vld, scw_rdy, irq;

  int total = 0;
  int bad   = 0;

  logic [1:0]  bq[$];
  logic [31:0] rdq[$];
  logic [1:0]  rrq[$];
  logic [31:0] cq[$];

  sockit_spi_axi_regs #(
    .CFG_RST (P_CFG_RST),
    .CFG_MSK (P_CFG_MSK),
    .XAW     (24),
    .OFF_RST (P_OFF_RST),
    .CDEPTH  (4)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .AWADDR  (AWADDR),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .BRESP   (BRESP),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .ARADDR  (ARADDR),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .cfg     (cfg),
    .off     (off),
    .scw_vld (scw_vld),
    .scw_dat (scw_dat),
    .scw_rdy (scw_rdy),
    .irq     (irq)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic get_b();
    int n = 0;
    logic [1:0] exp;
    BREADY = 1'b1;
    #1;
    while (!BVALID && n < 50) begin
      @(posedge ACLK); #2; n++;
    end
    total++;
    if (!BVALID) begin
      bad++;
      $display("FAIL b_timeout: BVALID got %b want 1", BVALID);
    end else begin
      exp = bq.pop_front();
      if (BRESP !== exp) begin
        bad++;
        $display("FAIL bresp: got %b want %b", BRESP, exp);
      end
    end
    tick();
    BREADY = 1'b0;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] resp);
    bit aw_done = 0, w_done = 0, a_rdy, w_rdy;
    int n = 0;
    bq.push_back(resp);
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      #1;
      a_rdy = AWVALID && AWREADY;
      w_rdy = WVALID && WREADY;
      tick();
      if (a_rdy) begin aw_done = 1; AWVALID = 1'b0; end
      if (w_rdy) begin w_done = 1; WVALID = 1'b0; end
      n++;
    end
    if (!(aw_done && w_done)) begin
      total++; bad++;
      $display("FAIL aw_w_timeout: addr %h got aw=%0d w=%0d want 1 1", a, aw_done, w_done);
      AWVALID = 1'b0; WVALID = 1'b0;
    end
    get_b();
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] d, input logic [1:0] resp);
    int n = 0;
    logic [31:0] ed;
    logic [1:0]  er;
    rdq.push_back(d); rrq.push_back(resp);
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
    #1;
    while (!ARREADY && n < 50) begin
      @(posedge ACLK); #2; n++;
    end
    tick();
    ARVALID = 1'b0;
    #1;
    total++;
    if (RVALID !== 1'b1) begin
      bad++;
      $display("FAIL r_latency: addr %h RVALID got %b want 1", a, RVALID);
    end
    n = 0;
    while (!RVALID && n < 50) begin
      @(posedge ACLK); #2; n++;
    end
    ed = rdq.pop_front(); er = rrq.pop_front();
    total++;
    if (RDATA !== ed || RRESP !== er) begin
      bad++;
      $display("FAIL rdata: addr %h got %h/%b want %h/%b", a, RDATA, RRESP, ed, er);
    end
    tick();
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 1; scw_rdy = 0;
    AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0;
    repeat (3) @(posedge ACLK);
    #2;
    total++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, scw_vld, irq} !== 7'b0) begin
      bad++;
      $display("FAIL rst_ctl: got %b want 0000000",
               {AWREADY, WREADY, ARREADY, BVALID, RVALID, scw_vld, irq});
    end
    total++;
    if (BRESP !== 2'b00 || RRESP !== 2'b00 || RDATA !== 32'h0) begin
      bad++;
      $display("FAIL rst_resp: got %b %b %h want 00 00 0", BRESP, RRESP, RDATA);
    end
    total++;
    if (cfg !== P_CFG_RST || off !== P_OFF_RST) begin
      bad++;
      $display("FAIL rst_regs: got cfg=%h off=%h want %h %h", cfg, off, P_CFG_RST, P_OFF_RST);
    end
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    tick(); tick();
    total++;
    if (AWREADY !== 1'b1 || WREADY !== 1'b1 || ARREADY !== 1'b1) begin
      bad++;
      $display("FAIL post_rst_ready: got %b%b%b want 111", AWREADY, WREADY, ARREADY);
    end
    axi_read(5'h04, 32'h0, 2'b00);
    axi_read(5'h08, 32'h0, 2'b00);
    axi_read(5'h0C, 32'h0, 2'b00);
    axi_read(5'h10, 32'(P_OFF_RST), 2'b00);
  endtask

  task automatic test_cfg_strb();
    axi_write(5'h00, 32'hA5A5_A5A5, 4'b0011, 2'b00);
    axi_read(5'h00, 32'h0000_A5A5, 2'b00);
    total++;
    if (cfg !== 32'h0000_A5A5) begin
      bad++;
      $display("FAIL cfg_port: got %h want 0000a5a5", cfg);
    end
    axi_write(5'h00, 32'hFFFF_FFFF, 4'b1100, 2'b00);
    axi_read(5'h00, 32'h0000_A5A5, 2'b00);
    axi_write(5'h00, 32'h1234_5A00, 4'b0010, 2'b00);
    axi_read(5'h00, 32'h0000_5AA5, 2'b00);
    axi_write(5'h00, 32'h0000_A5A5, 4'b0011, 2'b00);
  endtask

  task automatic test_w_before_aw();
    int n = 0;
    BREADY = 1'b0;
    WDATA = 32'h0012_3456; WSTRB = 4'hF; WVALID = 1'b1;
    #1;
    total++;
    if (WREADY !== 1'b1) begin
      bad++; $display("FAIL wfirst_wready: got %b want 1", WREADY);
    end
    tick();
    WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (WREADY !== 1'b0 || AWREADY !== 1'b1 || BVALID !== 1'b0) begin
        bad++;
        $display("FAIL wfirst_hold: got wr=%b awr=%b bv=%b want 0 1 0", WREADY, AWREADY, BVALID);
      end
      tick();
    end
    AWADDR = 5'h10; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    while (!BVALID && n < 20) begin tick(); n++; end
    // Second transaction arrives while the first response is still pending.
    AWADDR = 5'h0C; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (BVALID !== 1'b1 || BRESP !== 2'b00 || off !== 24'h12_3456) begin
        bad++;
        $display("FAIL b_hold: got bv=%b br=%b off=%h want 1 00 123456", BVALID, BRESP, off);
      end
      if (i == 0) begin
        total++;
        if (AWREADY !== 1'b1 || WREADY !== 1'b1) begin
          bad++; $display("FAIL b_hold_accept: got %b%b want 11", AWREADY, WREADY);
        end
      end else begin
        total++;
        if (AWREADY !== 1'b0 || WREADY !== 1'b0) begin
          bad++; $display("FAIL b_hold_stall: got %b%b want 00", AWREADY, WREADY);
        end
      end
      tick();
      if (i == 0) begin AWVALID = 1'b0; WVALID = 1'b0; end
    end
    BREADY = 1'b1;
    tick();
    total++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      bad++; $display("FAIL b_second: got %b %b want 1 00", BVALID, BRESP);
    end
    tick();
    BREADY = 1'b0;
    total++;
    if (BVALID !== 1'b0) begin
      bad++; $display("FAIL b_drained: got %b want 0", BVALID);
    end
    axi_read(5'h0C, 32'hDEAD_BEEF, 2'b00);
    axi_read(5'h10, 32'h0012_3456, 2'b00);
  endtask

  task automatic test_back_to_back();
    logic [4:0]  addrs [5];
    logic [31:0] vals  [5];
    logic [31:0] ed;
    logic [1:0]  er;
    int k = 0, got = 0;
    addrs[0] = 5'h00; vals[0] = 32'h0000_A5A5;
    addrs[1] = 5'h10; vals[1] = 32'h0012_3456;
    addrs[2] = 5'h0C; vals[2] = 32'hDEAD_BEEF;
    addrs[3] = 5'h04; vals[3] = 32'h0;
    addrs[4] = 5'h14; vals[4] = 32'h0;
    RREADY = 1'b1;
    while (got < 5 && k < 10) begin
      if (k < 5) begin
        ARVALID = 1'b1; ARADDR = addrs[k];
        rdq.push_back(vals[k]); rrq.push_back(2'b00);
      end else begin
        ARVALID = 1'b0;
      end
      #1;
      if (k < 5) begin
        total++;
        if (ARREADY !== 1'b1) begin
          bad++; $display("FAIL b2b_arready: beat %0d got %b want 1", k, ARREADY);
        end
      end
      if (k >= 1 && k <= 5) begin
        total++;
        if (RVALID !== 1'b1) begin
          bad++; $display("FAIL b2b_rvalid: beat %0d got %b want 1", k, RVALID);
        end
      end
      if (RVALID) begin
        ed = rdq.pop_front(); er = rrq.pop_front();
        total++;
        if (RDATA !== ed || RRESP !== er) begin
          bad++; $display("FAIL b2b_rdata: got %h/%b want %h/%b", RDATA, RRESP, ed, er);
        end
        got++;
      end
      tick();
      k++;
    end
    ARVALID = 1'b0;
    // Stalled read data must stay put while RREADY is low.
    RREADY = 1'b0; ARADDR = 5'h00; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0; ARADDR = 5'h10;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (RVALID !== 1'b1 || RDATA !== 32'h0000_A5A5 || ARREADY !== 1'b0) begin
        bad++;
        $display("FAIL r_stall: got v=%b d=%h ar=%b want 1 0000a5a5 0", RVALID, RDATA, ARREADY);
      end
      tick();
    end
    RREADY = 1'b1;
    tick();
    total++;
    if (RVALID !== 1'b0) begin
      bad++; $display("FAIL r_release: got %b want 0", RVALID);
    end
  endtask

  task automatic test_fifo();
    int pops = 0, n = 0;
    bit bseen = 0;
    logic [31:0] exp;
    scw_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cq.push_back(32'(i));
      axi_write(5'h14, 32'(i), 4'b0000, 2'b00);
    end
    axi_read(5'h04, 32'h8000_0004, 2'b00);
    axi_read(5'h14, 32'h0, 2'b00);
    BREADY = 1'b1;
    AWADDR = 5'h14; WDATA = 32'd5; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    cq.push_back(32'd5);
    #1;
    total++;
    if (AWREADY !== 1'b1 || WREADY !== 1'b1) begin
      bad++; $display("FAIL full_accept: got %b%b want 11", AWREADY, WREADY);
    end
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (BVALID !== 1'b0 || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
        bad++;
        $display("FAIL full_stall: got bv=%b awr=%b wr=%b want 0 0 0", BVALID, AWREADY, WREADY);
      end
      tick();
    end
    scw_rdy = 1'b1;
    while ((pops < 5 || !bseen) && n < 40) begin
      #1;
      if (scw_vld && scw_rdy) begin
        total++;
        if (cq.size() == 0) begin
          bad++; $display("FAIL cmd_extra: got %h want none", scw_dat);
        end else begin
          exp = cq.pop_front();
          if (scw_dat !== exp) begin
            bad++; $display("FAIL cmd_order: got %h want %h", scw_dat, exp);
          end
        end
        pops++;
      end
      if (BVALID) begin
        total++;
        if (bseen || pops < 1 || BRESP !== 2'b00) begin
          bad++;
          $display("FAIL full_b: got seen=%0d pops=%0d resp=%b want 0 >=1 00", bseen, pops, BRESP);
        end
        bseen = 1;
      end
      tick();
      n++;
    end
    total++;
    if (pops != 5 || !bseen) begin
      bad++; $display("FAIL drain: got pops=%0d b=%0d want 5 1", pops, bseen);
    end
    scw_rdy = 1'b0; BREADY = 1'b0;
    axi_read(5'h04, 32'h0, 2'b00);
    axi_read(5'h08, 32'h1, 2'b00);
  endtask

  task automatic test_irq();
    axi_write(5'h08, 32'h3, 4'h1, 2'b00);
    axi_write(5'h0C, 32'h1, 4'hF, 2'b00);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want 0", irq); end
    cq.push_back(32'h00C0_FFEE);
    axi_write(5'h14, 32'h00C0_FFEE, 4'hF, 2'b00);
    scw_rdy = 1'b1;
    #1;
    total++;
    if (scw_vld !== 1'b1 || scw_dat !== cq.pop_front()) begin
      bad++; $display("FAIL irq_pop: got vld=%b dat=%h want 1 00c0ffee", scw_vld, scw_dat);
    end
    tick();
    scw_rdy = 1'b0;
    axi_read(5'h08, 32'h1, 2'b00);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_set: got %b want 1", irq); end
    axi_write(5'h0C, 32'h0, 4'hF, 2'b00);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_mask: got %b want 0", irq); end
    axi_write(5'h0C, 32'h1, 4'hF, 2'b00);
    axi_write(5'h08, 32'h1, 4'h1, 2'b00);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_w1c: got %b want 0", irq); end
    // Set event and W1C clear land on the same edge.
    cq.push_back(32'h77);
    axi_write(5'h14, 32'h77, 4'hF, 2'b00);
    BREADY = 1'b0;
    AWADDR = 5'h08; WDATA = 32'h1; WSTRB = 4'h1; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    scw_rdy = 1'b1;
    #1;
    total++;
    if (scw_vld !== 1'b1 || scw_dat !== cq.pop_front()) begin
      bad++; $display("FAIL race_pop: got vld=%b dat=%h want 1 00000077", scw_vld, scw_dat);
    end
    tick();
    scw_rdy = 1'b0;
    bq.push_back(2'b00);
    get_b();
    axi_read(5'h08, 32'h1, 2'b00);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL race_irq: got %b want 1", irq); end
  endtask

  task automatic test_reserved();
    axi_write(5'h18, 32'hFFFF_FFFF, 4'hF, 2'b10);
    axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF, 2'b10);
    axi_read(5'h18, 32'h0, 2'b10);
    axi_read(5'h1C, 32'h0, 2'b10);
    axi_read(5'h08, 32'h3, 2'b00);
    axi_read(5'h00, 32'h0000_A5A5, 2'b00);
    axi_read(5'h0C, 32'h1, 2'b00);
    axi_read(5'h10, 32'h0012_3456, 2'b00);
    axi_read(5'h04, 32'h0, 2'b00);
  endtask

  task automatic test_async_reset();
    int n = 0;
    scw_rdy = 1'b0;
    axi_write(5'h14, 32'h11, 4'hF, 2'b00);
    axi_write(5'h14, 32'h22, 4'hF, 2'b00);
    BREADY = 1'b0;
    AWADDR = 5'h00; WDATA = 32'h0000_FFFF; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    while (!BVALID && n < 20) begin tick(); n++; end
    total++;
    if (BVALID !== 1'b1 || scw_vld !== 1'b1 || cfg !== 32'h0000_FFFF) begin
      bad++;
      $display("FAIL pre_rst: got bv=%b vld=%b cfg=%h want 1 1 0000ffff", BVALID, scw_vld, cfg);
    end
    #2;
    ARESETn = 1'b0;
    #1;
    total++;
    if (scw_vld !== 1'b0 || BVALID !== 1'b0 || cfg !== P_CFG_RST || off !== P_OFF_RST) begin
      bad++;
      $display("FAIL async_rst: got vld=%b bv=%b cfg=%h off=%h want 0 0 %h %h",
               scw_vld, BVALID, cfg, off, P_CFG_RST, P_OFF_RST);
    end
    total++;
    if (AWREADY !== 1'b0 || irq !== 1'b0) begin
      bad++; $display("FAIL async_rst_ctl: got awr=%b irq=%b want 0 0", AWREADY, irq);
    end
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    tick(); tick();
    axi_read(5'h04, 32'h0, 2'b00);
    axi_read(5'h00, P_CFG_RST, 2'b00);
    axi_read(5'h08, 32'h0, 2'b00);
  endtask

  initial begin
    test_reset();
    test_cfg_strb();
    test_w_before_aw();
    test_back_to_back();
    test_fifo();
    test_irq();
    test_reserved();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
